// File: rtl/sram_pkg.sv
// sram_pkg: shared geometry, margin settings and controller state encoding for the 512x32 SRAM path
package sram_pkg;
    localparam int SRAM_AW    = 9;
    localparam int SRAM_DW    = 32;
    localparam int SRAM_DEPTH = 512;
    localparam logic [2:0] SRAM_EMA  = 3'b011;
    localparam logic [1:0] SRAM_EMAW = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: 2-entry in-order read-response buffer
// Ports: CLK/RSTN clock and async active-low reset; push/wdata enqueue;
// pop dequeue; rdata head entry; valid head present; occ entries held (0..2).
module sram_rsp_fifo
    import sram_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               push,
    input  logic [SRAM_DW-1:0] wdata,
    input  logic               pop,
    output logic [SRAM_DW-1:0] rdata,
    output logic               valid,
    output logic [1:0]         occ
);
    logic [SRAM_DW-1:0] mem [2];
    logic wr_ptr, rd_ptr;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    assign rdata = mem[rd_ptr];
    assign valid = occ != 2'd0;
endmodule

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request/response front end for a 512x32 single-port SRAM macro with power-up zero fill
// Ports: CLK/RSTN clock and async active-low reset;
// req_valid/req_ready/req_we/req_addr/req_wdata request channel;
// rsp_valid/rsp_ready/rsp_rdata in-order read responses; init_done high in RUN;
// CEN/GWEN/A/D macro controls, Q macro read data; STOV..WABLM fixed macro margin pins.
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter bit INIT_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [SRAM_AW-1:0] req_addr,
    input  logic [SRAM_DW-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SRAM_DW-1:0] rsp_rdata,
    output logic               init_done,
    output logic               CEN,
    output logic               GWEN,
    output logic [SRAM_AW-1:0] A,
    output logic [SRAM_DW-1:0] D,
    input  logic [SRAM_DW-1:0] Q,
    output logic               STOV,
    output logic [2:0]         EMA,
    output logic [1:0]         EMAW,
    output logic               EMAS,
    output logic               RET1N,
    output logic               WABL,
    output logic [1:0]         WABLM
);
    state_t state, state_nxt;
    logic [SRAM_AW-1:0] init_cnt, a_q;
    logic [SRAM_DW-1:0] d_q;
    logic rd_inflight, run, init, req_fire, rsp_fire;
    logic [1:0] occ;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= ST_IDLE;
            init_cnt    <= '0;
            rd_inflight <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= init ? init_cnt + 1'b1 : '0;
            rd_inflight <= req_fire && !req_we;
            a_q         <= A;
            d_q         <= D;
        end
    end
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) state_nxt = INIT_EN ? ST_INIT : ST_RUN;
        else if (state == ST_INIT && &init_cnt) state_nxt = ST_RUN;
    end
    assign run       = state == ST_RUN;
    assign init      = state == ST_INIT;
    assign init_done = run;
    assign rsp_fire  = rsp_valid && rsp_ready;
    // A slot is free if buffered plus in-flight reads leave room, or the head leaves this cycle.
    assign req_ready = run && ((({1'b0, occ} + {2'b0, rd_inflight}) < 3'd2) || rsp_fire);
    assign req_fire  = req_valid && req_ready;
    assign CEN       = ~(init || req_fire);
    assign GWEN      = ~(init || (req_fire && req_we));
    // Address and data hold their previous values whenever the macro is idle.
    assign A         = init ? init_cnt : req_fire ? req_addr : a_q;
    assign D         = init ? '0 : req_fire ? req_wdata : d_q;
    assign STOV      = 1'b0;
    assign EMA       = SRAM_EMA;
    assign EMAW      = SRAM_EMAW;
    assign EMAS      = 1'b0;
    assign RET1N     = 1'b1;
    assign WABL      = 1'b0;
    assign WABLM     = 2'b00;
    sram_rsp_fifo u_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (rd_inflight),
        .wdata (Q),
        .pop   (rsp_fire),
        .rdata (rsp_rdata),
        .valid (rsp_valid),
        .occ   (occ)
    );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed self-checking bench for sram_req_ctrl with a behavioural SRAM macro
module tb_sram_req_ctrl;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [8:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, rsp_valid, init_done, CEN, GWEN, STOV, EMAS, RET1N, WABL;
    logic [31:0] rsp_rdata, D, Q;
    logic [8:0] A;
    logic [2:0] EMA;
    logic [1:0] EMAW, WABLM;
    logic req_ready0, rsp_valid0, init_done0, CEN0, GWEN0, STOV0, EMAS0, RET1N0, WABL0;
    logic [31:0] rsp_rdata0, D0;
    logic [8:0] A0;
    logic [2:0] EMA0;
    logic [1:0] EMAW0, WABLM0;
    logic [31:0] mem [512];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic v, we;
        logic [8:0] addr;
        logic [31:0] wd;
        logic rr, e_rdy, e_rv;
        logic [31:0] e_rd;
        logic e_cen, e_gwen;
        logic [8:0] e_a;
    } vec_t;
    vec_t tv [24];
    int nv = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) mem[A] <= D;
            else Q <= mem[A];
        end
    end

    sram_req_ctrl #(.INIT_EN(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .init_done(init_done), .CEN(CEN), .GWEN(GWEN), .A(A), .D(D), .Q(Q),
        .STOV(STOV), .EMA(EMA), .EMAW(EMAW), .EMAS(EMAS), .RET1N(RET1N), .WABL(WABL), .WABLM(WABLM)
    );

    sram_req_ctrl #(.INIT_EN(1'b0)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata0), .init_done(init_done0), .CEN(CEN0), .GWEN(GWEN0), .A(A0), .D(D0),
        .Q(32'd0), .STOV(STOV0), .EMA(EMA0), .EMAW(EMAW0), .EMAS(EMAS0), .RET1N(RET1N0),
        .WABL(WABL0), .WABLM(WABLM0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic we, input logic [8:0] addr, input logic [31:0] wd,
                       input logic rr, input logic e_rdy, input logic e_rv, input logic [31:0] e_rd,
                       input logic e_cen, input logic e_gwen, input logic [8:0] e_a);
        tv[nv] = '{v, we, addr, wd, rr, e_rdy, e_rv, e_rd, e_cen, e_gwen, e_a};
        nv++;
    endtask

    task automatic chk_reset_forced(input string tag);
        chk({tag, "_cen"}, 32'(CEN), 32'd1);
        chk({tag, "_gwen"}, 32'(GWEN), 32'd1);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done"}, 32'(init_done), 32'd0);
        chk({tag, "_a"}, 32'(A), 32'd0);
        chk({tag, "_d"}, D, 32'd0);
    endtask

    // Releases reset and walks IDLE, the 512 zero-fill writes and the first RUN cycle.
    task automatic do_init();
        int bad = 0;
        int bad0 = 0;
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        chk("idle_cen", 32'(CEN), 32'd1);
        chk("idle_done", 32'(init_done), 32'd0);
        for (int k = 0; k < 512; k++) begin
            @(negedge CLK);
            #1;
            if (CEN !== 1'b0 || GWEN !== 1'b0 || A !== 9'(k) || D !== 32'd0 ||
                req_ready !== 1'b0 || init_done !== 1'b0) bad++;
            if (k == 0) chk("noinit_done", 32'(init_done0), 32'd1);
            if (CEN0 !== 1'b1) bad0++;
        end
        chk("init_bad_cycles", 32'(bad), 32'd0);
        chk("noinit_writes", 32'(bad0), 32'd0);
        @(negedge CLK);
        #1;
        chk("run_done", 32'(init_done), 32'd1);
        chk("run_ready", 32'(req_ready), 32'd1);
        chk("run_cen", 32'(CEN), 32'd1);
    endtask

    initial begin
        int bad;
        // v we addr wd rr | rdy rv rdata cen gwen A
        add('1, '1, 9'd0, 32'd5, '1, '1, '0, 32'd0, '0, '0, 9'd0);
        add('1, '1, 9'd1, 32'd6, '1, '1, '0, 32'd0, '0, '0, 9'd1);
        add('1, '1, 9'd2, 32'd7, '1, '1, '0, 32'd0, '0, '0, 9'd2);
        add('1, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '0, '1, 9'd0);
        add('1, '0, 9'd2, 32'd0, '1, '1, '0, 32'd0, '0, '1, 9'd2);
        add('1, '0, 9'd1, 32'd0, '1, '1, '1, 32'd5, '0, '1, 9'd1);
        add('0, '0, 9'd0, 32'd0, '1, '1, '1, 32'd7, '1, '1, 9'd1);
        add('0, '0, 9'd0, 32'd0, '1, '1, '1, 32'd6, '1, '1, 9'd1);
        add('0, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '1, '1, 9'd1);
        add('1, '0, 9'd0, 32'd0, '0, '1, '0, 32'd0, '0, '1, 9'd0);
        add('1, '0, 9'd1, 32'd0, '0, '1, '0, 32'd0, '0, '1, 9'd1);
        add('1, '0, 9'd2, 32'd0, '0, '0, '1, 32'd5, '1, '1, 9'd1);
        add('1, '0, 9'd2, 32'd0, '0, '0, '1, 32'd5, '1, '1, 9'd1);
        add('1, '0, 9'd2, 32'd0, '0, '0, '1, 32'd5, '1, '1, 9'd1);
        add('1, '0, 9'd2, 32'd0, '1, '1, '1, 32'd5, '0, '1, 9'd2);
        add('0, '0, 9'd0, 32'd0, '1, '1, '1, 32'd6, '1, '1, 9'd2);
        add('0, '0, 9'd0, 32'd0, '1, '1, '1, 32'd7, '1, '1, 9'd2);
        add('0, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '1, '1, 9'd2);
        add('1, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '0, '1, 9'd0);
        add('1, '1, 9'd0, 32'd9, '1, '1, '0, 32'd0, '0, '0, 9'd0);
        add('1, '0, 9'd0, 32'd0, '1, '1, '1, 32'd5, '0, '1, 9'd0);
        add('0, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '1, '1, 9'd0);
        add('0, '0, 9'd0, 32'd0, '1, '1, '1, 32'd9, '1, '1, 9'd0);
        add('0, '0, 9'd0, 32'd0, '1, '1, '0, 32'd0, '1, '1, 9'd0);

        #12;
        chk_reset_forced("rst");
        chk("ema", 32'(EMA), 32'd3);
        chk("emaw", 32'(EMAW), 32'd1);
        chk("ret1n", 32'(RET1N), 32'd1);
        chk("zero_pins", 32'({STOV, EMAS, WABL, WABLM}), 32'd0);
        do_init();

        for (int i = 0; i < nv; i++) begin
            @(negedge CLK);
            req_valid = tv[i].v;
            req_we = tv[i].we;
            req_addr = tv[i].addr;
            req_wdata = tv[i].wd;
            rsp_ready = tv[i].rr;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d_rv", i), 32'(rsp_valid), 32'(tv[i].e_rv));
            if (tv[i].e_rv) chk($sformatf("v%0d_rdata", i), rsp_rdata, tv[i].e_rd);
            chk($sformatf("v%0d_cen", i), 32'(CEN), 32'(tv[i].e_cen));
            chk($sformatf("v%0d_gwen", i), 32'(GWEN), 32'(tv[i].e_gwen));
            chk($sformatf("v%0d_a", i), 32'(A), 32'(tv[i].e_a));
        end

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            req_valid = 1'b1;
            req_we = 1'b1;
            req_addr = 9'(10 + i);
            req_wdata = 32'(i * 3 + 1);
            rsp_ready = 1'b1;
            #1;
            if (req_ready !== 1'b1 || D !== 32'(i * 3 + 1) || GWEN !== 1'b0) bad++;
        end
        chk("b2b_writes", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            req_valid = i < 20;
            req_we = 1'b0;
            req_addr = 9'(10 + i);
            #1;
            if (i < 20 && req_ready !== 1'b1) bad++;
            if (rsp_valid !== (i >= 2)) bad++;
            if (i >= 2 && rsp_rdata !== 32'((i - 2) * 3 + 1)) bad++;
        end
        chk("b2b_reads", 32'(bad), 32'd0);

        @(negedge CLK);
        req_valid = 1'b1;
        req_addr = 9'd10;
        rsp_ready = 1'b0;
        @(negedge CLK);
        req_addr = 9'd11;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        #1;
        chk("buf2_rv", 32'(rsp_valid), 32'd1);
        chk("buf2_ready", 32'(req_ready), 32'd0);
        chk("buf2_rdata", rsp_rdata, 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk_reset_forced("rst_buf");
        do_init();

        @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        for (int k = 0; k <= 300; k++) @(negedge CLK);
        #1;
        chk("mid_init_a", 32'(A), 32'd300);
        chk("mid_init_cen", 32'(CEN), 32'd0);
        #2;
        RSTN = 1'b0;
        #1;
        chk_reset_forced("rst_init");
        do_init();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
